// File: rtl/ram_march_bist.sv
// March C- BIST controller for a single-port synchronous RAM.
// The controller drives we/addr/din directly and checks dout one cycle after each read.
// Results are sticky: a pass/fail flag, a saturating error count and the details of the first failure.
module ram_march_bist #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 11,
  parameter int                 DEPTH   = 1024,
  parameter logic [DATA_W-1:0]  PATTERN = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ph_q, ph_d;        // 0 = cycle A (read), 1 = cycle B (compare/write)
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;
  logic [DATA_W-1:0]   fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0]   fail_act_q, fail_act_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                cmp, mism, last;
  logic [DATA_W-1:0]   exp_w;

  // E3 and E4 walk the address space downwards.
  function automatic logic is_desc(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Word expected on a read: E2 and E4 read the "1" background.
  function automatic logic [DATA_W-1:0] rd_word(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? ~PATTERN : PATTERN;
  endfunction

  // Word written: E1 and E3 write the "1" background, E0/E2/E4 write "0".
  function automatic logic [DATA_W-1:0] wr_word(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? ~PATTERN : PATTERN;
  endfunction

  // Next-state, march sequencing, compare/capture and RAM-port decode.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    ph_d        = ph_q;
    done_d      = done_q;
    fail_d      = fail_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    exp_w       = rd_word(elem_q);
    cmp         = (state_q == RUN) && (elem_q != 3'd0) && ph_q;
    // Case inequality so that an X on dout is flagged as a mismatch in simulation.
    mism        = cmp && (ram_dout !== exp_w);
    last        = is_desc(elem_q) ? (addr_q == '0) : (addr_q == LAST);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          elem_d      = 3'd0;
          addr_d      = '0;
          ph_d        = 1'b0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
        end
      end
      RUN: begin
        if (elem_q == 3'd0) begin
          if (addr_q == LAST) begin
            elem_d = 3'd1;
            addr_d = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end else if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (last) begin
            if (elem_q == 3'd5) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = is_desc(elem_q + 3'd1) ? LAST : '0;
            end
          end else begin
            addr_d = is_desc(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
        if (mism) begin
          fail_d = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          if (!fail_q) begin
            fail_addr_d = addr_q;
            fail_elem_d = elem_q;
            fail_exp_d  = exp_w;
            fail_act_d  = ram_dout;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // RAM port outputs are registered, so decode them from the next state.
    busy_d     = (state_d == RUN);
    ram_we_d   = (state_d == RUN) && ((elem_d == 3'd0) || (ph_d && (elem_d != 3'd5)));
    ram_addr_d = (state_d == RUN) ? addr_d : '0;
    ram_din_d  = ram_we_d ? wr_word(elem_d) : '0;
  end

  // State and registered outputs; reset forces everything low immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      ph_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      ph_q        <= ph_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: two instances (DEPTH 16 and DEPTH 1000), each driving a RAM model
// with an optional stuck-at bit. The reference model walks March C- over an array.
module tb_ram_march_bist;

  localparam logic [31:0] P = 32'h0000_0000;

  typedef struct packed {
    logic        we;
    logic [10:0] addr;
    logic [31:0] din;
  } acc_t;

  logic clk = 1'b0, rst = 1'b1, st1 = 1'b0, st2 = 1'b0;
  always #5 clk = ~clk;

  logic        busy1, done1, fail1, we1, busy2, done2, fail2, we2;
  logic [15:0] ecnt1, ecnt2;
  logic [10:0] faddr1, addr1, faddr2, addr2;
  logic [2:0]  felem1, felem2;
  logic [31:0] fexp1, fact1, din1, dout1, fexp2, fact2, din2, dout2;

  ram_march_bist #(.DATA_W(32), .ADDR_W(11), .DEPTH(16), .PATTERN(P)) u_dut16 (
    .clk(clk), .rst(rst), .start(st1), .busy(busy1), .done(done1), .fail(fail1),
    .err_cnt(ecnt1), .fail_addr(faddr1), .fail_elem(felem1), .fail_exp(fexp1),
    .fail_act(fact1), .ram_we(we1), .ram_addr(addr1), .ram_din(din1), .ram_dout(dout1));

  ram_march_bist #(.DATA_W(32), .ADDR_W(11), .DEPTH(1000), .PATTERN(P)) u_dut1000 (
    .clk(clk), .rst(rst), .start(st2), .busy(busy2), .done(done2), .fail(fail2),
    .err_cnt(ecnt2), .fail_addr(faddr2), .fail_elem(felem2), .fail_exp(fexp2),
    .fail_act(fact2), .ram_we(we2), .ram_addr(addr2), .ram_din(din2), .ram_dout(dout2));

  // Stuck-at fault shared by both RAM models (only one instance runs at a time).
  bit          f_en;
  logic [10:0] f_addr;
  int          f_bit;
  logic        f_val;

  function automatic logic [31:0] fix(input logic [10:0] a, input logic [31:0] v);
    logic [31:0] r = v;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [31:0] mem1 [16];
  logic [31:0] mem2 [1024];
  int oob1 = 0, oob2 = 0;

  always @(posedge clk) begin
    if (we1 && addr1 < 11'd16) mem1[addr1[3:0]] <= din1;
    if (busy1 && addr1 >= 11'd16) oob1 <= oob1 + 1;
    dout1 <= (addr1 < 11'd16) ? fix(addr1, mem1[addr1[3:0]]) : 'x;
  end

  always @(posedge clk) begin
    if (we2 && addr2 < 11'd1000) mem2[addr2[9:0]] <= din2;
    if (busy2 && addr2 >= 11'd1000) oob2 <= oob2 + 1;
    dout2 <= (addr2 < 11'd1000) ? fix(addr2, mem2[addr2[9:0]]) : 'x;
  end

  int npass = 0, ncheck = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncheck++;
    if (got !== exp) $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else npass++;
  endtask

  // Reference model: March C- over a plain array, producing the access trace and the result.
  acc_t        exp_q[$], act_q[$];
  logic [31:0] mm [1024];
  int          m_cnt;
  logic [10:0] m_addr;
  logic [2:0]  m_elem;
  logic [31:0] m_exp, m_act;

  task automatic model(input int depth);
    // per element: 0 = write only, 1 = read+write, 2 = read only
    int          kind [6] = '{0, 1, 1, 1, 1, 2};
    bit          down [6] = '{0, 0, 0, 1, 1, 0};
    logic [31:0] rv   [6] = '{P, P, ~P, P, ~P, P};
    logic [31:0] wv   [6] = '{P, ~P, P, ~P, P, P};
    exp_q.delete();
    m_cnt = 0; m_addr = 0; m_elem = 0; m_exp = 0; m_act = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < depth; i++) begin
        logic [10:0] a;
        logic [31:0] v;
        a = 11'(down[e] ? depth - 1 - i : i);
        if (kind[e] != 0) begin
          exp_q.push_back('{1'b0, a, 32'h0});
          v = fix(a, mm[a]);
          if (v !== rv[e]) begin
            if (m_cnt == 0) begin
              m_addr = a; m_elem = 3'(e); m_exp = rv[e]; m_act = v;
            end
            m_cnt++;
          end
        end
        if (kind[e] == 2) exp_q.push_back('{1'b0, a, 32'h0});
        else begin
          exp_q.push_back('{1'b1, a, wv[e]});
          mm[a] = wv[e];
        end
      end
    end
  endtask

  // Pulse start, then record one RAM access per busy cycle until busy drops (bounded).
  task automatic run(input bit sel, input int pulse_at, input int rst_at, output int n);
    int limit = (sel ? 11000 : 176) + 20;
    act_q.delete();
    n = 0;
    @(negedge clk);
    if (sel) st2 = 1'b1; else st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0; st2 = 1'b0;
    while (n < limit && (sel ? busy2 : busy1)) begin
      if (n == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_async_status", {busy1, done1, fail1, ecnt1, we1, addr1, din1}, 64'h0);
        chk("rst_async_capture", {faddr1, felem1, fact1}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      act_q.push_back(sel ? acc_t'{we2, addr2, din2} : acc_t'{we1, addr1, din1});
      n++;
      st1 = (!sel && n == pulse_at);
      @(negedge clk);
    end
    st1 = 1'b0;
  endtask

  task automatic check_run(input bit sel, input int n, input string tag);
    int bad = 0;
    int depth = sel ? 1000 : 16;
    if (act_q.size() != exp_q.size()) bad++;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i].we !== exp_q[i].we || act_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].we && act_q[i].din !== exp_q[i].din)) bad++;
    chk({tag, "_busy_cycles"}, 64'(n), 64'(11 * depth));
    chk({tag, "_trace"}, 64'(bad), 64'h0);
    if (sel) begin
      chk({tag, "_done_fail"}, {done2, fail2, busy2, we2}, {1'b1, m_cnt != 0, 2'b00});
      chk({tag, "_err_cnt"}, 64'(ecnt2), 64'(m_cnt));
      chk({tag, "_oob"}, 64'(oob2), 64'h0);
      chk({tag, "_done_port"}, {addr2, din2}, 64'h0);
    end else begin
      chk({tag, "_done_fail"}, {done1, fail1, busy1, we1}, {1'b1, m_cnt != 0, 2'b00});
      chk({tag, "_err_cnt"}, 64'(ecnt1), 64'(m_cnt));
      chk({tag, "_fail_where"}, {faddr1, felem1}, {m_addr, m_elem});
      chk({tag, "_fail_exp"}, 64'(fexp1), 64'(m_exp));
      chk({tag, "_fail_act"}, 64'(fact1), 64'(m_act));
      chk({tag, "_oob"}, 64'(oob1), 64'h0);
    end
  endtask

  task automatic set_fault(input bit en, input int a, input int b, input logic v);
    f_en = en; f_addr = 11'(a); f_bit = b; f_val = v;
  endtask

  initial begin
    int n;
    set_fault(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_status", {busy1, done1, fail1, ecnt1, we1, addr1, din1}, 64'h0);
    chk("reset_capture", {faddr1, felem1, fexp1}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    model(16); run(0, -1, -1, n); check_run(0, n, "clean16");

    set_fault(1, 5, 0, 1'b1);
    model(16); run(0, -1, -1, n); check_run(0, n, "sa1_a5");
    chk("sa1_a5_plan_cnt", 64'(ecnt1), 64'd3);

    set_fault(1, 9, 31, 1'b0);
    model(16); run(0, -1, -1, n); check_run(0, n, "sa0_a9");
    chk("sa0_a9_plan", {felem1, fact1}, {3'd2, 32'h7FFF_FFFF});

    for (int k = 0; k < 4; k++) begin
      set_fault(1, $urandom_range(0, 15), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      model(16); run(0, -1, -1, n); check_run(0, n, $sformatf("rand%0d", k));
    end

    set_fault(1, 5, 0, 1'b1);
    model(16); run(0, 40, -1, n); check_run(0, n, "restart_ignored");

    set_fault(1, 0, 0, 1'b1);
    run(0, -1, 50, n);
    set_fault(0, 0, 0, 0);
    model(16); run(0, -1, -1, n); check_run(0, n, "after_rst");

    model(1000); run(1, -1, -1, n); check_run(1, n, "clean1000");

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
